// File: rtl/fetch_unit.sv
// Purpose: instruction fetch stage; word-indexed PC, direct-jump detect, IF/ID pipeline register.
// Latency: one cycle from rom_addr presentation to the instruction appearing on if_instr/if_pc.
// Backpressure: stall holds PC and IF/ID; redirect/flush insert a bubble and override stall.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus1,
  output logic [31:0] fetch_count
);

  // Primary opcode of the absolute direct jump (J-type).
  localparam logic [5:0] OP_JUMP = 6'b000010;

  // Architectural state
  logic [31:0] pc_q,          pc_d;
  logic        if_valid_q,    if_valid_d;
  logic [31:0] if_pc_q,       if_pc_d;
  logic [31:0] if_instr_q,    if_instr_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  // Decode helpers for the word currently returned by the ROM
  logic [31:0] pc_plus1;
  logic        is_jump;
  logic [31:0] jump_target;
  logic        ifid_clear;
  logic        ifid_load;

  // Sequential PC and jump-target arithmetic; the jump keeps the region bits of PC+1.
  always_comb begin
    pc_plus1    = pc_q + 32'd1;
    is_jump     = (rom_data[31:26] == OP_JUMP);
    jump_target = {pc_plus1[31:26], rom_data[25:0]};
  end

  // IF/ID control: redirect or flush squash the entry, otherwise stall freezes it.
  always_comb begin
    ifid_clear = redirect_valid | flush;
    ifid_load  = ~ifid_clear & ~stall;
  end

  // Next PC: redirect beats stall, stall beats jump, jump beats sequential.
  always_comb begin
    pc_d = pc_plus1;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (is_jump) begin
      pc_d = jump_target;
    end
  end

  // Next IF/ID contents and fetch counter; a squashed entry is zeroed, not just invalidated.
  always_comb begin
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    fetch_count_d = fetch_count_q;
    if (ifid_clear) begin
      if_valid_d = 1'b0;
      if_pc_d    = 32'd0;
      if_instr_d = 32'd0;
    end else if (ifid_load) begin
      if_valid_d    = 1'b1;
      if_pc_d       = pc_q;
      if_instr_d    = rom_data;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // PC register; reset drops any in-flight fetch and restarts at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID pipeline register and fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'd0;
      if_instr_q    <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Outputs: rom_addr comes straight from the register so the ROM sees no input-to-output path.
  always_comb begin
    rom_addr    = pc_q;
    if_valid    = if_valid_q;
    if_pc       = if_pc_q;
    if_instr    = if_instr_q;
    if_pc_plus1 = if_pc_q + 32'd1;
    fetch_count = fetch_count_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] rom_addr, rom_data;
  logic        if_valid;
  logic [31:0] if_pc, if_instr, if_pc_plus1, fetch_count;

  logic [31:0] rom_mem [0:255];
  assign rom_data = rom_mem[rom_addr[7:0]];

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .rom_addr(rom_addr), .rom_data(rom_data), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr), .if_pc_plus1(if_pc_plus1),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural view of the fetch stage
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_vld = 1'b0; m_ipc = 32'd0; m_instr = 32'd0; m_cnt = 32'd0;
  endtask

  // One clock edge of the fetch rules, applied to the current inputs.
  task automatic model_step();
    logic [31:0] word, seq, npc;
    word = rom_mem[m_pc[7:0]];
    seq  = m_pc + 32'd1;
    if (redirect_valid)               npc = redirect_target;
    else if (stall)                   npc = m_pc;
    else if (word[31:26] == 6'd2)     npc = {seq[31:26], word[25:0]};
    else                              npc = seq;
    if (redirect_valid || flush) begin
      m_vld = 1'b0; m_ipc = 32'd0; m_instr = 32'd0;
    end else if (!stall) begin
      m_vld = 1'b1; m_ipc = m_pc; m_instr = word; m_cnt = m_cnt + 32'd1;
    end
    m_pc = npc;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rom_addr"},    rom_addr,            m_pc);
    chk({tag, ".if_valid"},    {31'd0, if_valid},   {31'd0, m_vld});
    chk({tag, ".if_pc"},       if_pc,               m_ipc);
    chk({tag, ".if_instr"},    if_instr,            m_instr);
    chk({tag, ".if_pc_plus1"}, if_pc_plus1,         m_ipc + 32'd1);
    chk({tag, ".fetch_count"}, fetch_count,         m_cnt);
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] t);
    stall = s; flush = f; redirect_valid = r; redirect_target = t;
  endtask

  // Advance one edge: update model, then sample just after the edge.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] cnt_save;
    logic [31:0] seq_exp [0:6];
    seq_exp[0] = 0; seq_exp[1] = 1; seq_exp[2] = 2; seq_exp[3] = 3;
    seq_exp[4] = 4; seq_exp[5] = 0; seq_exp[6] = 1;

    for (int i = 0; i < 256; i++) rom_mem[i] = 32'h1000_0000 + i;
    rom_mem[0] = 32'h2001_00FF;
    rom_mem[1] = 32'h2002_02E9;
    rom_mem[2] = 32'h0020_1820;
    rom_mem[3] = 32'hAC03_0000;
    rom_mem[4] = 32'h0800_0000;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Sequential fetch with a jump back to 0
    for (int i = 0; i < 7; i++) begin
      cycle("seq");
      chk("seq.if_pc_const", if_pc, seq_exp[i]);
      chk("seq.valid_const", {31'd0, if_valid}, 32'd1);
    end
    chk("seq.count7", fetch_count, 32'd7);

    // Stall two cycles with if_pc == 2
    cycle("pre_stall");
    chk("stall.if_pc_pre", if_pc, 32'd2);
    cnt_save = fetch_count;
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cycle("stall");
      chk("stall.if_pc", if_pc, 32'd2);
      chk("stall.if_instr", if_instr, 32'h0020_1820);
      chk("stall.rom_addr", rom_addr, 32'd3);
      chk("stall.count", fetch_count, cnt_save);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    cycle("resume");
    chk("resume.if_pc", if_pc, 32'd3);

    // Redirect to 0x10 while rom_addr == 3
    drive(1'b0, 1'b0, 1'b1, 32'd3);
    cycle("to3");
    drive(1'b0, 1'b0, 1'b1, 32'h10);
    cycle("redir");
    chk("redir.valid", {31'd0, if_valid}, 32'd0);
    chk("redir.rom_addr", rom_addr, 32'h10);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    cycle("redir_next");
    chk("redir_next.if_pc", if_pc, 32'h10);
    chk("redir_next.valid", {31'd0, if_valid}, 32'd1);

    // Redirect + stall + jump at rom_addr == 4
    drive(1'b0, 1'b0, 1'b1, 32'd4);
    cycle("to4");
    drive(1'b1, 1'b0, 1'b1, 32'd2);
    cycle("rsj");
    chk("rsj.rom_addr", rom_addr, 32'd2);
    chk("rsj.valid", {31'd0, if_valid}, 32'd0);

    // Flush alone at rom_addr == 1
    drive(1'b0, 1'b0, 1'b1, 32'd1);
    cycle("to1");
    cnt_save = fetch_count;
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    cycle("flush");
    chk("flush.valid", {31'd0, if_valid}, 32'd0);
    chk("flush.rom_addr", rom_addr, 32'd2);
    chk("flush.count", fetch_count, cnt_save);

    // Asynchronous reset between edges with if_pc == 3
    drive(1'b0, 1'b0, 1'b1, 32'd3);
    cycle("to3b");
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    cycle("at3");
    chk("arst.if_pc_pre", if_pc, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    chk("arst.count", fetch_count, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_all("arst_hold");
    end
    #2 rst_n = 1'b1;
    cycle("arst_rel");
    chk("arst_rel.if_pc", if_pc, RESET_PC);
    chk("arst_rel.valid", {31'd0, if_valid}, 32'd1);

    // PC wrap
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    cycle("wrap_set");
    chk("wrap.rom_addr_top", rom_addr, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    cycle("wrap");
    chk("wrap.rom_addr", rom_addr, 32'd0);
    chk("wrap.if_pc", if_pc, 32'hFFFF_FFFF);
    chk("wrap.if_pc_plus1", if_pc_plus1, 32'd0);

    // Randomized traffic: random ROM with some jumps, random control inputs
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 7) == 0)
        rom_mem[i] = {6'b000010, 26'($urandom)};
      else
        rom_mem[i] = {6'b000001 + 6'($urandom_range(0, 40)), 26'($urandom)};
    end
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, $urandom);
      cycle("rand");
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
